// File: rtl/dac_pkg.sv
// Shared definitions for the multi-channel AD5061 serial driver.
//   state_t     channel-sequencing FSM states
//   FRAME_W     bits per DAC frame
//   PD_*        power-down field encodings
//   make_frame  builds {6'b0, pd, data16}
package dac_pkg;

   localparam int FRAME_W = 24;

   localparam logic [1:0] PD_NORMAL   = 2'b00;
   localparam logic [1:0] PD_1K_GND   = 2'b01;
   localparam logic [1:0] PD_100K_GND = 2'b10;
   localparam logic [1:0] PD_TRISTATE = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP,
      DONE
   } state_t;

   function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0]  pd,
                                                      input logic [15:0] data);
      return {6'b0, pd, data};
   endfunction

endpackage

// File: rtl/dac_frame_shifter.sv
// Serialises one 24-bit frame MSB first with an idle-high SCLK.
// Each bit is CLK_DIV cycles high then CLK_DIV cycles low; data moves only
// when SCLK rises, so it is stable across the falling (sample) edge.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   start      load frame and begin with bit 23 (SCLK high)
//   frame      frame to send
//   sclk, sdo  serial clock / data
//   last_bit   high in the cycle whose edge ends bit 0's low phase
module dac_frame_shifter
   import dac_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame,
   output logic               sclk,
   output logic               sdo,
   output logic               last_bit
);

   localparam logic [15:0] HALF_MAX = 16'(CLK_DIV - 1);
   localparam logic [4:0]  BIT_MAX  = 5'(FRAME_W - 1);

   logic [FRAME_W-1:0] sreg;
   logic [15:0]        half_cnt;
   logic [4:0]         bit_cnt;
   logic               active;

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg     <= '0;
         half_cnt <= '0;
         bit_cnt  <= '0;
         sclk     <= 1'b1;
         active   <= 1'b0;
      end else if (start) begin
         sreg     <= frame;
         half_cnt <= HALF_MAX;
         bit_cnt  <= BIT_MAX;
         sclk     <= 1'b1;
         active   <= 1'b1;
      end else if (active) begin
         if (half_cnt != '0) begin
            half_cnt <= half_cnt - 16'd1;
         end else begin
            half_cnt <= HALF_MAX;
            if (sclk) begin
               sclk <= 1'b0;
            end else begin
               // rising edge: next bit; after bit 0 the register is all zero
               sclk <= 1'b1;
               sreg <= sreg << 1;
               if (bit_cnt == '0) active <= 1'b0;
               else               bit_cnt <= bit_cnt - 5'd1;
            end
         end
      end
   end

   assign sdo      = sreg[FRAME_W-1];
   assign last_bit = active && (half_cnt == '0) && !sclk && (bit_cnt == '0);

endmodule

// File: rtl/dac_ad5061_multi.sv
// Multi-channel AD5061 driver: one latch captures all channel words and a
// common power-down mode, then frames are sent on channel 0..CHANNELS-1,
// each followed by a 2*CLK_DIV cycle gap with every SYNC high.
// Optional build macro DAC_SKIP_UNCHANGED_EN: channels whose frame matches
// the last one sent are skipped (reset marks every channel dirty).
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   latch      start strobe, accepted only in IDLE
//   value      channel n at [n*DATA_W +: DATA_W]
//   pd_mode    PD1:PD0 for all channels
//   busy, done sequence in progress / one-cycle completion pulse
//   sync_dac   per-channel active-low SYNC
//   clk_dac    SCLK (idle high), sdo_dac  SDIN
//
// state | meaning
// IDLE  | waiting for latch
// SHIFT | frame on channel idx in progress
// GAP   | all SYNC high between frames
// DONE  | one-cycle done pulse
module dac_ad5061_multi
   import dac_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 16,
   parameter int CLK_DIV  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       latch,
   input  logic [CHANNELS*DATA_W-1:0] value,
   input  logic [1:0]                 pd_mode,
   output logic                       busy,
   output logic                       done,
   output logic [CHANNELS-1:0]        sync_dac,
   output logic                       clk_dac,
   output logic                       sdo_dac
);

   localparam logic [15:0] GAP_MAX = 16'(2 * CLK_DIV - 1);

   state_t                     state, state_nxt;
   logic [2:0]                 idx, nxt_idx;
   logic [15:0]                gap_cnt;
   logic [CHANNELS*DATA_W-1:0] shadow_val, src_val;
   logic [1:0]                 shadow_pd, src_pd;
   logic [CHANNELS-1:0]        pend, dirty_in, src_mask;
   logic [FRAME_W-1:0]         start_frame;
   logic                       start, last_bit;

   function automatic logic [15:0] align(input logic [DATA_W-1:0] d);
      logic [15:0] t;
      t = '0;
      t[15 -: DATA_W] = d;
      return t;
   endfunction

   function automatic logic [2:0] first_set(input logic [CHANNELS-1:0] mask);
      logic [2:0] r;
      r = '0;
      for (int n = CHANNELS - 1; n >= 0; n--)
         if (mask[n]) r = 3'(n);
      return r;
   endfunction

`ifdef DAC_SKIP_UNCHANGED_EN
   logic [CHANNELS-1:0] sent_valid;
   logic [17:0]         last_sent [CHANNELS];

   always_comb begin
      dirty_in = '0;
      for (int n = 0; n < CHANNELS; n++)
         dirty_in[n] = !sent_valid[n] ||
                       (last_sent[n] != {pd_mode, align(value[n*DATA_W +: DATA_W])});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sent_valid <= '0;
         for (int n = 0; n < CHANNELS; n++) last_sent[n] <= '0;
      end else if (state == SHIFT && last_bit) begin
         for (int n = 0; n < CHANNELS; n++)
            if (3'(n) == idx) begin
               sent_valid[n] <= 1'b1;
               last_sent[n]  <= {shadow_pd, align(shadow_val[n*DATA_W +: DATA_W])};
            end
      end
   end
`else
   assign dirty_in = '1;
`endif

   // In IDLE the first frame comes straight from the inputs so SYNC can fall
   // on the accepting edge; later frames come from the shadow registers.
   always_comb begin
      src_mask    = (state == IDLE) ? dirty_in : pend;
      src_val     = (state == IDLE) ? value    : shadow_val;
      src_pd      = (state == IDLE) ? pd_mode  : shadow_pd;
      nxt_idx     = first_set(src_mask);
      start_frame = make_frame(src_pd, align(src_val[nxt_idx*DATA_W +: DATA_W]));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE:
            if (latch) begin
               // nothing dirty: GAP with a zero count gives the one busy cycle
               if (|dirty_in) begin
                  state_nxt = SHIFT;
                  start     = 1'b1;
               end else begin
                  state_nxt = GAP;
               end
            end
         SHIFT:
            if (last_bit) state_nxt = GAP;
         GAP:
            if (gap_cnt == '0) begin
               if (|pend) begin
                  state_nxt = SHIFT;
                  start     = 1'b1;
               end else begin
                  state_nxt = DONE;
               end
            end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == SHIFT) || (state == GAP);
      done     = (state == DONE);
      sync_dac = (state == SHIFT) ? ~(CHANNELS'(1) << idx) : '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         gap_cnt    <= '0;
         shadow_val <= '0;
         shadow_pd  <= PD_NORMAL;
         pend       <= '0;
      end else begin
         if (state == IDLE && latch) begin
            shadow_val <= value;
            shadow_pd  <= pd_mode;
            pend       <= dirty_in;
            gap_cnt    <= '0;
         end
         if (start) idx <= nxt_idx;
         if (state == SHIFT && last_bit) begin
            pend    <= pend & ~(CHANNELS'(1) << idx);
            gap_cnt <= GAP_MAX;
         end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 16'd1;
         end
      end
   end

   dac_frame_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .frame    (start_frame),
      .sclk     (clk_dac),
      .sdo      (sdo_dac),
      .last_bit (last_bit)
   );

endmodule

// File: tb/tb_dac_ad5061_multi.sv
module tb_dac_ad5061_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   // instance A: 2 channels, 16 bits, CLK_DIV=2
   logic        latch_a = 1'b0;
   logic [31:0] value_a = '0;
   logic [1:0]  pd_a    = 2'b00;
   logic        busy_a, done_a, clk_dac_a, sdo_a;
   logic [1:0]  sync_a;

   // instance B: 4 channels, 12 bits, CLK_DIV=1
   logic        latch_b = 1'b0;
   logic [47:0] value_b = '0;
   logic [1:0]  pd_b    = 2'b00;
   logic        busy_b, done_b, clk_dac_b, sdo_b;
   logic [3:0]  sync_b;

   dac_ad5061_multi #(.CHANNELS(2), .DATA_W(16), .CLK_DIV(2)) dut_a (
      .clk(clk), .rst(rst), .latch(latch_a), .value(value_a), .pd_mode(pd_a),
      .busy(busy_a), .done(done_a), .sync_dac(sync_a), .clk_dac(clk_dac_a), .sdo_dac(sdo_a));

   dac_ad5061_multi #(.CHANNELS(4), .DATA_W(12), .CLK_DIV(1)) dut_b (
      .clk(clk), .rst(rst), .latch(latch_b), .value(value_b), .pd_mode(pd_b),
      .busy(busy_b), .done(done_b), .sync_dac(sync_b), .clk_dac(clk_dac_b), .sdo_dac(sdo_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Receiving-DAC model: shift on falling SCLK while SYNC low, keep a frame
   // only when SYNC rises after exactly 24 falling edges.
   int          busy_cnt_a = 0, low_cnt_a = 0, overlap = 0, glitch = 0;
   logic [23:0] sh_a [2];
   logic [23:0] frm_a [2];
   int          cnt_a [2] = '{0, 0};
   int          num_a [2] = '{0, 0};
   int          fall_a [2] = '{0, 0};
   logic        prev_sclk_a = 1'b1, prev_sdo_a = 1'b0;
   logic [1:0]  prev_sync_a = 2'b11;

   int          busy_cnt_b = 0;
   logic [23:0] sh_b [4];
   logic [23:0] frm_b [4];
   int          cnt_b [4] = '{0, 0, 0, 0};
   int          num_b [4] = '{0, 0, 0, 0};
   int          fall_b [4] = '{0, 0, 0, 0};
   logic        prev_sclk_b = 1'b1;
   logic [3:0]  prev_sync_b = 4'hF;

   always @(negedge clk) begin
      if (busy_a) busy_cnt_a++;
      if (sync_a != 2'b11) low_cnt_a++;
      if ($countones(~sync_a) > 1 || $countones(~sync_b) > 1) overlap++;
      if (!rst && sync_a == prev_sync_a && sync_a != 2'b11 && sdo_a !== prev_sdo_a
          && !(!prev_sclk_a && clk_dac_a)) glitch++;
      for (int n = 0; n < 2; n++) begin
         if (!sync_a[n] && prev_sclk_a && !clk_dac_a) begin
            sh_a[n] = {sh_a[n][22:0], sdo_a};
            cnt_a[n]++;
         end
         if (prev_sync_a[n] && !sync_a[n]) begin
            fall_a[n] = cyc;
            cnt_a[n] = 0;
         end
         if (!prev_sync_a[n] && sync_a[n]) begin
            if (cnt_a[n] == 24) begin
               frm_a[n] = sh_a[n];
               num_a[n]++;
            end
            cnt_a[n] = 0;
         end
      end
      prev_sclk_a = clk_dac_a;
      prev_sdo_a  = sdo_a;
      prev_sync_a = sync_a;

      if (busy_b) busy_cnt_b++;
      for (int n = 0; n < 4; n++) begin
         if (!sync_b[n] && prev_sclk_b && !clk_dac_b) begin
            sh_b[n] = {sh_b[n][22:0], sdo_b};
            cnt_b[n]++;
         end
         if (prev_sync_b[n] && !sync_b[n]) begin
            fall_b[n] = cyc;
            cnt_b[n] = 0;
         end
         if (!prev_sync_b[n] && sync_b[n]) begin
            if (cnt_b[n] == 24) begin
               frm_b[n] = sh_b[n];
               num_b[n]++;
            end
            cnt_b[n] = 0;
         end
      end
      prev_sclk_b = clk_dac_b;
      prev_sync_b = sync_b;
   end

   task automatic wait_done(input bit use_b, input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (use_b ? done_b : done_a) begin
            at = cyc;
            break;
         end
      end
      checks++;
      if (at < 0) begin
         errors++;
         $display("FAIL done_timeout got no done within %0d cycles", limit);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks += 6;
      if (busy_a !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", busy_a); end
      if (done_a !== 1'b0)      begin errors++; $display("FAIL rst_done got %b exp 0", done_a); end
      if (sync_a !== 2'b11)     begin errors++; $display("FAIL rst_sync got %b exp 11", sync_a); end
      if (clk_dac_a !== 1'b1)   begin errors++; $display("FAIL rst_sclk got %b exp 1", clk_dac_a); end
      if (sdo_a !== 1'b0)       begin errors++; $display("FAIL rst_sdo got %b exp 0", sdo_a); end
      if (sync_b !== 4'hF)      begin errors++; $display("FAIL rst_sync_b got %h exp f", sync_b); end
      rst = 1'b0;
   endtask

   // latch at cycle 20, re-pulse at cycle 60 with new data (must be ignored)
   task automatic test_basic;
      int b0, n0, n1, at;
      value_a = {16'hABCD, 16'h4321};
      pd_a    = 2'b00;
      while (cyc < 18) @(negedge clk);
      b0 = busy_cnt_a; n0 = num_a[0]; n1 = num_a[1];
      @(negedge clk); latch_a = 1'b1;
      @(negedge clk); latch_a = 1'b0;
      checks += 5;
      if (cyc != 20)          begin errors++; $display("FAIL latch_edge got %0d exp 20", cyc); end
      if (busy_a !== 1'b1)    begin errors++; $display("FAIL first_busy got %b exp 1", busy_a); end
      if (sync_a !== 2'b10)   begin errors++; $display("FAIL first_sync got %b exp 10", sync_a); end
      if (clk_dac_a !== 1'b1) begin errors++; $display("FAIL first_sclk got %b exp 1", clk_dac_a); end
      if (sdo_a !== 1'b0)     begin errors++; $display("FAIL first_sdo got %b exp 0", sdo_a); end
      repeat (2) @(negedge clk);
      checks++;
      if (clk_dac_a !== 1'b0) begin errors++; $display("FAIL sclk_low_phase got %b exp 0", clk_dac_a); end
      while (cyc < 59) @(negedge clk);
      latch_a = 1'b1; value_a = {16'h1111, 16'h2222};
      @(negedge clk); latch_a = 1'b0;
      wait_done(1'b0, 400, at);
      checks += 7;
      if (at != 220)                   begin errors++; $display("FAIL done_cycle got %0d exp 220", at); end
      if (busy_cnt_a - b0 != 200)      begin errors++; $display("FAIL busy_len got %0d exp 200", busy_cnt_a - b0); end
      if (frm_a[0] !== 24'h004321)     begin errors++; $display("FAIL frame_ch0 got %h exp 004321", frm_a[0]); end
      if (frm_a[1] !== 24'h00ABCD)     begin errors++; $display("FAIL frame_ch1 got %h exp 00abcd", frm_a[1]); end
      if (num_a[0] - n0 != 1 || num_a[1] - n1 != 1)
         begin errors++; $display("FAIL frame_count got %0d/%0d exp 1/1", num_a[0] - n0, num_a[1] - n1); end
      if (fall_a[0] != 20)             begin errors++; $display("FAIL sync0_fall got %0d exp 20", fall_a[0]); end
      if (fall_a[1] - fall_a[0] != 100) begin errors++; $display("FAIL slot_len got %0d exp 100", fall_a[1] - fall_a[0]); end
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0) begin errors++; $display("FAIL done_width got %b exp 0", done_a); end
   endtask

   task automatic test_pd;
      int at;
      value_a = {16'h1234, 16'h0000};
      pd_a    = 2'b11;
      @(negedge clk); latch_a = 1'b1;
      @(negedge clk); latch_a = 1'b0;
      wait_done(1'b0, 400, at);
      checks += 2;
      if (frm_a[0] !== 24'h030000) begin errors++; $display("FAIL pd_frame_ch0 got %h exp 030000", frm_a[0]); end
      if (frm_a[1] !== 24'h031234) begin errors++; $display("FAIL pd_frame_ch1 got %h exp 031234", frm_a[1]); end
   endtask

   // latch held in the DONE cycle is dropped; first IDLE cycle is accepted
   task automatic test_done_latch;
      int at, n0;
      value_a = {16'h5A5A, 16'hA5A5};
      pd_a    = 2'b00;
      @(negedge clk); latch_a = 1'b1;
      @(negedge clk); latch_a = 1'b0;
      wait_done(1'b0, 400, at);
      n0 = num_a[0];
      latch_a = 1'b1; value_a = {16'h1111, 16'h2222};
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0) begin errors++; $display("FAIL done_latch_busy got %b exp 0", busy_a); end
      value_a = {16'h7777, 16'h8888}; pd_a = 2'b01;
      @(negedge clk); latch_a = 1'b0;
      checks++;
      if (busy_a !== 1'b1) begin errors++; $display("FAIL idle_latch_busy got %b exp 1", busy_a); end
      wait_done(1'b0, 400, at);
      checks += 3;
      if (frm_a[0] !== 24'h018888) begin errors++; $display("FAIL relatch_ch0 got %h exp 018888", frm_a[0]); end
      if (frm_a[1] !== 24'h017777) begin errors++; $display("FAIL relatch_ch1 got %h exp 017777", frm_a[1]); end
      if (num_a[0] - n0 != 1)      begin errors++; $display("FAIL relatch_count got %0d exp 1", num_a[0] - n0); end
   endtask

   task automatic test_reset_mid;
      int at, n0, i;
      value_a = {16'h0F0F, 16'hF0F0};
      pd_a    = 2'b10;
      @(negedge clk); latch_a = 1'b1;
      @(negedge clk); latch_a = 1'b0;
      n0 = num_a[0];
      i = 0;
      while (cnt_a[0] < 13 && i < 200) begin @(negedge clk); i++; end
      checks++;
      if (cnt_a[0] != 13) begin errors++; $display("FAIL abort_reach got %0d bits exp 13", cnt_a[0]); end
      rst = 1'b1;
      @(negedge clk);
      checks += 5;
      if (sync_a !== 2'b11)   begin errors++; $display("FAIL abort_sync got %b exp 11", sync_a); end
      if (clk_dac_a !== 1'b1) begin errors++; $display("FAIL abort_sclk got %b exp 1", clk_dac_a); end
      if (busy_a !== 1'b0)    begin errors++; $display("FAIL abort_busy got %b exp 0", busy_a); end
      if (sdo_a !== 1'b0)     begin errors++; $display("FAIL abort_sdo got %b exp 0", sdo_a); end
      if (num_a[0] != n0)     begin errors++; $display("FAIL abort_frame_kept got %0d exp %0d", num_a[0], n0); end
      rst = 1'b0;
      @(negedge clk); latch_a = 1'b1;
      @(negedge clk); latch_a = 1'b0;
      wait_done(1'b0, 400, at);
      checks += 2;
      if (frm_a[0] !== 24'h02F0F0) begin errors++; $display("FAIL after_rst_ch0 got %h exp 02f0f0", frm_a[0]); end
      if (frm_a[1] !== 24'h020F0F) begin errors++; $display("FAIL after_rst_ch1 got %h exp 020f0f", frm_a[1]); end
   endtask

   // same words latched again
   task automatic test_repeat;
      int at, b0, l0, n0, n1, le;
      b0 = busy_cnt_a; l0 = low_cnt_a; n0 = num_a[0]; n1 = num_a[1];
      @(negedge clk); latch_a = 1'b1;
      @(negedge clk); latch_a = 1'b0;
      le = cyc;
      wait_done(1'b0, 400, at);
      checks += 4;
`ifdef DAC_SKIP_UNCHANGED_EN
      if (busy_cnt_a - b0 != 1) begin errors++; $display("FAIL skip_busy got %0d exp 1", busy_cnt_a - b0); end
      if (at - le != 1)         begin errors++; $display("FAIL skip_done got %0d exp 1", at - le); end
      if (low_cnt_a != l0)      begin errors++; $display("FAIL skip_sync_low got %0d exp 0", low_cnt_a - l0); end
      if (num_a[0] != n0 || num_a[1] != n1)
         begin errors++; $display("FAIL skip_frames got %0d exp 0", num_a[0] - n0 + num_a[1] - n1); end
`else
      if (busy_cnt_a - b0 != 200) begin errors++; $display("FAIL repeat_busy got %0d exp 200", busy_cnt_a - b0); end
      if (at - le != 200)         begin errors++; $display("FAIL repeat_done got %0d exp 200", at - le); end
      if (low_cnt_a - l0 != 192)  begin errors++; $display("FAIL repeat_sync_low got %0d exp 192", low_cnt_a - l0); end
      if (num_a[0] - n0 != 1 || num_a[1] - n1 != 1)
         begin errors++; $display("FAIL repeat_frames got %0d exp 2", num_a[0] - n0 + num_a[1] - n1); end
`endif
   endtask

   task automatic test_div1;
      int at, b0, le;
      value_b = {12'h001, 12'h800, 12'h123, 12'hFFF};
      pd_b    = 2'b00;
      b0 = busy_cnt_b;
      @(negedge clk); latch_b = 1'b1;
      @(negedge clk); latch_b = 1'b0;
      le = cyc;
      wait_done(1'b1, 400, at);
      checks += 7;
      if (frm_b[0] !== 24'h00FFF0) begin errors++; $display("FAIL b_frame_ch0 got %h exp 00fff0", frm_b[0]); end
      if (frm_b[1] !== 24'h001230) begin errors++; $display("FAIL b_frame_ch1 got %h exp 001230", frm_b[1]); end
      if (frm_b[2] !== 24'h008000) begin errors++; $display("FAIL b_frame_ch2 got %h exp 008000", frm_b[2]); end
      if (frm_b[3] !== 24'h000010) begin errors++; $display("FAIL b_frame_ch3 got %h exp 000010", frm_b[3]); end
      if (fall_b[1] - fall_b[0] != 50) begin errors++; $display("FAIL b_slot got %0d exp 50", fall_b[1] - fall_b[0]); end
      if (busy_cnt_b - b0 != 200)  begin errors++; $display("FAIL b_busy got %0d exp 200", busy_cnt_b - b0); end
      if (at - le != 200)          begin errors++; $display("FAIL b_done got %0d exp 200", at - le); end
   endtask

   task automatic test_invariants;
      checks += 2;
      if (overlap != 0) begin errors++; $display("FAIL sync_overlap got %0d exp 0", overlap); end
      if (glitch != 0)  begin errors++; $display("FAIL sdo_moved_off_rise got %0d exp 0", glitch); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_pd;
      test_done_latch;
      test_reset_mid;
      test_repeat;
      test_div1;
      test_invariants;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
